// File: rtl/hdmi_scan_controller.sv
// hdmi_scan_controller
//   Raster timing generator and one-entry prefetching pixel fetcher that sits between
//   the frame-buffer memory interface and the TMDS encode/serialize path.
//
// Ports
//   system_clk      in   system clock, all logic on the rising edge
//   rst             in   synchronous active-high reset
//   data_ready      in   memory has valid data_line for the current request
//   data_line       in   24-bit {R,G,B} pixel from memory
//   read_request    out  fetch request to memory
//   address_line    out  linear pixel index being fetched
//   pixel_en        out  one-cycle strobe, once per CLK_DIV cycles
//   pixel_out       out  pixel to encoders, valid with pixel_en
//   de/hsync/vsync  out  raster timing, active high
//   frame_done      out  pulse with the pixel_en of the last raster position
//   underflow       out  pulse: active slot found no buffered pixel
//
// Optional feature
//   SCAN_UNDERFLOW_CNT_EN: adds underflow_count[15:0], a saturating count of underflow
//   pulses, cleared only by rst.

module hdmi_scan_controller #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned ADDR_W   = 20
) (
    input  logic              system_clk,
    input  logic              rst,
    input  logic              data_ready,
    input  logic [23:0]       data_line,
    output logic              read_request,
    output logic [ADDR_W-1:0] address_line,
    output logic              pixel_en,
    output logic [23:0]       pixel_out,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_done,
    output logic              underflow
`ifdef SCAN_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_count
`endif
);

    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned PIX_TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned DIV_W     = $clog2(CLK_DIV);
    localparam int unsigned HW        = $clog2(H_TOTAL);
    localparam int unsigned VW        = $clog2(V_TOTAL);

    typedef enum logic [1:0] {StIdle, StReq, StFull} fetch_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    fetch_state_t     state;
    logic [23:0]      pix_buf;

    logic        tick, active, hs_pos, vs_pos, last_pos;
    logic        consume, bypass, take_buf, uflow_set, addr_adv;
    logic [31:0] h_ext, v_ext;

    always_comb begin
        h_ext    = 32'(h_cnt);
        v_ext    = 32'(v_cnt);
        tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
        active   = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        hs_pos   = (h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC);
        vs_pos   = (v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC);
        last_pos = (h_ext == H_TOTAL - 1) && (v_ext == V_TOTAL - 1);
        consume  = tick && active;
        // Empty buffer but the outstanding request completes this very cycle: forward it.
        bypass    = consume && (state == StReq) && data_ready;
        take_buf  = consume && (state == StFull);
        uflow_set = consume && !bypass && !take_buf;
        addr_adv  = bypass || take_buf;
    end

    assign read_request = (state == StReq);

    always_ff @(posedge system_clk) begin
        if (rst) begin
            div_cnt      <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            state        <= StIdle;
            pix_buf      <= '0;
            address_line <= '0;
            pixel_en     <= 1'b0;
            pixel_out    <= '0;
            de           <= 1'b0;
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            frame_done   <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            pixel_en   <= tick;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);

            if (tick) begin
                de         <= active;
                hsync      <= hs_pos;
                vsync      <= vs_pos;
                frame_done <= last_pos;
                underflow  <= uflow_set;
                if (take_buf) begin
                    pixel_out <= pix_buf;
                end else if (bypass) begin
                    pixel_out <= data_line;
                end else begin
                    pixel_out <= '0;
                end
                if (h_ext == H_TOTAL - 1) begin
                    h_cnt <= '0;
                    v_cnt <= (v_ext == V_TOTAL - 1) ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end

            if (addr_adv) begin
                address_line <= (32'(address_line) == PIX_TOTAL - 1) ? '0
                                                                      : address_line + ADDR_W'(1);
            end

            unique case (state)
                StIdle: state <= StReq;
                StReq: begin
                    // A bypassed response is consumed immediately; keep requesting the next one.
                    if (data_ready && !consume) begin
                        pix_buf <= data_line;
                        state   <= StFull;
                    end
                end
                StFull: begin
                    if (consume) state <= StReq;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef SCAN_UNDERFLOW_CNT_EN
    always_ff @(posedge system_clk) begin
        if (rst) begin
            underflow_count <= '0;
        end else if (uflow_set && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_scan_controller.sv
// tb_hdmi_scan_controller
//   Randomized bench for hdmi_scan_controller with a small raster (8 x 5, CLK_DIV 2).
//   The reference model works at the transaction level: every completed memory handshake
//   pushes one pixel into a queue, every active raster slot pops one (or expects an
//   underflow), and raster outputs are computed arithmetically from the pixel index.

module tb_hdmi_scan_controller;

    localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int unsigned VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int unsigned DIV = 2, AW = 20;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned NPIX = HA * VA;

    logic          system_clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_ready = 1'b0;
    logic [23:0]   data_line = '0;
    logic          read_request;
    logic [AW-1:0] address_line;
    logic          pixel_en;
    logic [23:0]   pixel_out;
    logic          de, hsync, vsync, frame_done, underflow;
`ifdef SCAN_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_count;
`endif

    hdmi_scan_controller #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CLK_DIV  (DIV), .ADDR_W (AW)
    ) dut (
        .system_clk   (system_clk),
        .rst          (rst),
        .data_ready   (data_ready),
        .data_line    (data_line),
        .read_request (read_request),
        .address_line (address_line),
        .pixel_en     (pixel_en),
        .pixel_out    (pixel_out),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .frame_done   (frame_done),
        .underflow    (underflow)
`ifdef SCAN_UNDERFLOW_CNT_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    always #5 system_clk = ~system_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int unsigned cyc;
    int unsigned hs_count;
    int unsigned uf_count;
    logic [23:0] pix_q[$];
    bit          hs_prev;
    logic [23:0] hs_data;
    logic        e_de, e_hs, e_vs;
    logic [23:0] e_pix;

    task automatic do_reset(input int cycles);
        @(negedge system_clk);
        rst = 1'b1;
        repeat (cycles) begin
            data_ready = 1'($urandom_range(1));
            data_line  = 24'($urandom);
            @(negedge system_clk);
        end
        check("rst_read_request", 32'(read_request), 32'd0);
        check("rst_address", 32'(address_line), 32'd0);
        check("rst_pixel_en", 32'(pixel_en), 32'd0);
        check("rst_pixel_out", 32'(pixel_out), 32'd0);
        check("rst_timing", {28'd0, de, hsync, vsync, frame_done}, 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
`ifdef SCAN_UNDERFLOW_CNT_EN
        check("rst_underflow_count", 32'(underflow_count), 32'd0);
`endif
        rst        = 1'b0;
        cyc        = 0;
        hs_count   = 0;
        uf_count   = 0;
        hs_prev    = 1'b0;
        e_de       = 1'b0;
        e_hs       = 1'b0;
        e_vs       = 1'b0;
        e_pix      = '0;
        pix_q.delete();
        data_ready = 1'($urandom_range(1));
        data_line  = 24'($urandom);
    endtask

    // pct: probability (percent) that data_ready is offered in a given cycle
    task automatic run(input int cycles, input int unsigned pct);
        int unsigned n, h, v;
        bit          pen, fd, uf;
        repeat (cycles) begin
            @(negedge system_clk);
            cyc++;
            if (hs_prev) pix_q.push_back(hs_data);
            pen = (cyc % DIV == 0);
            fd  = 1'b0;
            uf  = 1'b0;
            if (pen) begin
                n    = cyc / DIV - 1;
                h    = n % HT;
                v    = (n / HT) % VT;
                e_de = (h < HA) && (v < VA);
                e_hs = (h >= HA + HF) && (h < HA + HF + HS);
                e_vs = (v >= VA + VF) && (v < VA + VF + VS);
                fd   = (h == HT - 1) && (v == VT - 1);
                if (!e_de) begin
                    e_pix = '0;
                end else if (pix_q.size() > 0) begin
                    e_pix = pix_q.pop_front();
                end else begin
                    e_pix = '0;
                    uf    = 1'b1;
                    uf_count++;
                end
            end
            check("pixel_en", 32'(pixel_en), 32'(pen));
            check("de", 32'(de), 32'(e_de));
            check("hsync", 32'(hsync), 32'(e_hs));
            check("vsync", 32'(vsync), 32'(e_vs));
            check("frame_done", 32'(frame_done), 32'(fd));
            check("underflow", 32'(underflow), 32'(uf));
            check("pixel_out", 32'(pixel_out), 32'(e_pix));
            // The single buffer slot is requested exactly when it is empty.
            check("read_request", 32'(read_request), 32'(pix_q.size() == 0));
            if (read_request) check("address_line", 32'(address_line), hs_count % NPIX);
`ifdef SCAN_UNDERFLOW_CNT_EN
            check("underflow_count", 32'(underflow_count), uf_count);
`endif
            data_ready = ($urandom_range(99) < pct);
            data_line  = 24'($urandom);
            hs_prev    = read_request && data_ready;
            hs_data    = data_line;
            if (hs_prev) hs_count++;
        end
    endtask

    initial begin
        do_reset(3);
        run(1, 0);
        // Zero-wait responder for two full frames plus change.
        run(170, 100);

        // Memory stalls at the start of line 0 of a fresh frame.
        do_reset(1);
        run(4, 0);
        run(156, 100);

        // Randomly stalling responder at several duty cycles.
        do_reset(2);
        run(400, 60);
        run(400, 25);
        run(200, 90);

        // Reset mid-frame while a request is outstanding, then restart.
        do_reset(1);
        run(22, 0);
        check("mid_req_outstanding", 32'(read_request), 32'd1);
        do_reset(1);
        run(1, 0);
        run(200, 75);

        // Starved for two frames: every active slot underflows.
        do_reset(1);
        run(160, 0);
        check("uf_model_two_frames", uf_count, 32'd16);
`ifdef SCAN_UNDERFLOW_CNT_EN
        check("underflow_count_two_frames", 32'(underflow_count), 32'd16);
`endif
        do_reset(2);
        run(100, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
